// File: rtl/ascon_intr_pkg.sv
// Shared constants, channel state types and the byte-strobe merge helper
// for the ASCON interrupt controller register bank.
package ascon_intr_pkg;

    localparam logic [2:0] ADDR_GIE = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_ISR = 3'd2;
    localparam logic [2:0] ADDR_IAR = 3'd3;
    localparam logic [2:0] ADDR_IPR = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/ascon_intr_pending_bank.sv
// Rising-edge detection and pending latch for the interrupt sources;
// a new edge wins over a same-cycle acknowledge.
module ascon_intr_pending_bank #(
    parameter int unsigned NUM_INTR = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_INTR-1:0] intr_src_i,
    input  logic [NUM_INTR-1:0] ier_i,
    input  logic [NUM_INTR-1:0] ack_i,
    input  logic                ack_valid_i,
    output logic [NUM_INTR-1:0] pending_o,
    output logic [NUM_INTR-1:0] ipr_o
);

    logic [NUM_INTR-1:0] intr_src_q, intr_src_d;
    logic [NUM_INTR-1:0] pending_q, pending_d;
    logic [NUM_INTR-1:0] rise;

    always_comb begin
        intr_src_d = intr_src_i;
        rise       = intr_src_i & ~intr_src_q & ier_i;
        pending_d  = pending_q;
        if (ack_valid_i) begin
            pending_d = pending_d & ~ack_i;
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            intr_src_q <= '0;
            pending_q  <= '0;
        end else begin
            intr_src_q <= intr_src_d;
            pending_q  <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign ipr_o     = pending_q & ier_i;

endmodule

// File: rtl/ascon_intr_axil_slave.sv
// AXI4-Lite register bank for the ASCON interrupt controller: GIE, IER,
// ISR, IAR and IPR behind independent write and read channels.
module ascon_intr_axil_slave
    import ascon_intr_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_NUM_OF_INTR      = 1,
    parameter int unsigned C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [C_NUM_OF_INTR-1:0]          intr_src,
    output logic                              irq
);

    localparam int unsigned N      = C_NUM_OF_INTR;
    localparam logic        IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic gie_q, gie_d, irq_q, irq_d;
    logic [N-1:0] ier_q, ier_d;

    logic [N-1:0] pending, ipr;
    logic         wr_fire, rd_fire, ack_valid;
    logic [31:0]  wr_gie_word, wr_ier_word, ack_word, rd_word;
    logic [2:0]   wr_idx, rd_idx;

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];

    always_comb begin
        wr_state_d  = wr_state_q;
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        bvalid_d    = bvalid_q;
        gie_d       = gie_q;
        ier_d       = ier_q;
        ack_valid   = 1'b0;
        wr_fire     = awready_q & wready_q & S_AXI_AWVALID & S_AXI_WVALID;
        wr_gie_word = strb_merge({31'd0, gie_q}, S_AXI_WDATA, S_AXI_WSTRB);
        wr_ier_word = strb_merge(32'(ier_q), S_AXI_WDATA, S_AXI_WSTRB);
        ack_word    = strb_merge(32'd0, S_AXI_WDATA, S_AXI_WSTRB);
        case (wr_state_q)
            WrIdle: begin
                if (wr_fire) begin
                    wr_state_d = WrResp;
                    bvalid_d   = 1'b1;
                    case (wr_idx)
                        ADDR_GIE: gie_d     = wr_gie_word[0];
                        ADDR_IER: ier_d     = wr_ier_word[N-1:0];
                        ADDR_IAR: ack_valid = 1'b1;
                        default:  ;
                    endcase
                end else if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            WrResp: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read data comes from the current flop values, so a same-cycle write is not visible.
    always_comb begin
        case (rd_idx)
            ADDR_GIE: rd_word = {31'd0, gie_q};
            ADDR_IER: rd_word = 32'(ier_q);
            ADDR_ISR: rd_word = 32'(pending);
            ADDR_IPR: rd_word = 32'(ipr);
            default:  rd_word = 32'd0;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rd_fire    = arready_q & S_AXI_ARVALID;
        case (rd_state_q)
            RdIdle: begin
                if (rd_fire) begin
                    rdata_d    = rd_word;
                    rvalid_d   = 1'b1;
                    rd_state_d = RdData;
                end else if (S_AXI_ARVALID && !rvalid_q && !arready_q) begin
                    arready_d = 1'b1;
                end
            end
            RdData: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
        irq_d = (gie_q && (ipr != '0)) ? IRQ_ON : ~IRQ_ON;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            gie_q      <= 1'b0;
            ier_q      <= '0;
            irq_q      <= ~IRQ_ON;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            irq_q      <= irq_d;
        end
    end

    ascon_intr_pending_bank #(
        .NUM_INTR (N)
    ) u_pending_bank (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .intr_src_i  (intr_src),
        .ier_i       (ier_q),
        .ack_i       (ack_word[N-1:0]),
        .ack_valid_i (ack_valid),
        .pending_o   (pending),
        .ipr_o       (ipr)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign irq           = irq_q;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                           wr_gie_word, wr_ier_word, ack_word};

endmodule

// File: tb/tb_ascon_intr_axil_slave.sv
// Directed plus randomized bench for the interrupt register bank, checked
// against a cycle-level behavioural model of the register map.
module tb_ascon_intr_axil_slave;

    localparam int unsigned N = 4;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [N-1:0] intr_src = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;
    bit rand_src = 1'b0;

    always #5 ACLK = ~ACLK;

    ascon_intr_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_NUM_OF_INTR      (N),
        .C_IRQ_ACTIVE_STATE (1)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .intr_src      (intr_src),
        .irq           (irq)
    );

    // Behavioural model: register contents plus expected read data per AR handshake.
    logic         m_gie = 1'b0;
    logic [N-1:0] m_ier = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_src_prev = '0;
    logic         m_irq = 1'b0;
    logic [31:0]  rd_exp_q[$];

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        logic [2:0] idx;
        idx = addr[4:2];
        case (idx)
            3'd0:    return {31'd0, m_gie};
            3'd1:    return 32'(m_ier);
            3'd2:    return 32'(m_pend);
            3'd4:    return 32'(m_pend & m_ier);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge ACLK) begin : model_p
        logic [N-1:0] rise;
        logic [N-1:0] nxt;
        logic [31:0]  merged;
        logic [2:0]   widx;
        logic         irq_nxt;
        if (!ARESETN) begin
            m_gie      = 1'b0;
            m_ier      = '0;
            m_pend     = '0;
            m_src_prev = '0;
            m_irq      = 1'b0;
            rd_exp_q.delete();
        end else begin
            irq_nxt = m_gie && ((m_pend & m_ier) != '0);
            if (S_AXI_ARVALID && S_AXI_ARREADY) rd_exp_q.push_back(model_read(S_AXI_ARADDR));
            rise = '0;
            for (int i = 0; i < N; i++) begin
                if (intr_src[i] && !m_src_prev[i] && m_ier[i]) rise[i] = 1'b1;
            end
            nxt  = m_pend;
            widx = S_AXI_AWADDR[4:2];
            if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY) begin
                case (widx)
                    3'd0: begin
                        merged = apply_strb(model_read(5'h00), S_AXI_WDATA, S_AXI_WSTRB);
                        m_gie  = merged[0];
                    end
                    3'd1: begin
                        merged = apply_strb(model_read(5'h04), S_AXI_WDATA, S_AXI_WSTRB);
                        m_ier  = merged[N-1:0];
                    end
                    3'd3: begin
                        merged = apply_strb(32'd0, S_AXI_WDATA, S_AXI_WSTRB);
                        nxt    = nxt & ~merged[N-1:0];
                    end
                    default: ;
                endcase
            end
            m_pend     = nxt | rise;
            m_src_prev = intr_src;
            m_irq      = irq_nxt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        check("irq_model", 32'(irq), 32'(m_irq));
        if (rand_src) intr_src = N'($urandom);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay, input bit edge_at_commit);
        int t;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 20) begin
            step();
            t++;
        end
        check("awready_seen", 32'(S_AXI_AWREADY), 32'd1);
        check("wready_seen", 32'(S_AXI_WREADY), 32'd1);
        if (edge_at_commit) intr_src[0] = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
        check("bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("bresp", 32'(S_AXI_BRESP), 32'd0);
        repeat (bdelay) begin
            step();
            check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            check("bresp_hold", 32'(S_AXI_BRESP), 32'd0);
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        check("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int rdelay, output logic [31:0] data);
        int t;
        logic [31:0] exp;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < 20) begin
            step();
            t++;
        end
        check("arready_seen", 32'(S_AXI_ARREADY), 32'd1);
        step();
        S_AXI_ARVALID = 1'b0;
        check("rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("rresp", 32'(S_AXI_RRESP), 32'd0);
        data = S_AXI_RDATA;
        repeat (rdelay) begin
            step();
            check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            check("rdata_hold", S_AXI_RDATA, data);
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        check("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
        check("rd_exp_avail", 32'(rd_exp_q.size()), 32'd1);
        if (rd_exp_q.size() != 0) begin
            exp = rd_exp_q.pop_front();
            check("rdata_model", data, exp);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [4:0]  a;
        ARESETN = 1'b0;
        repeat (20) @(negedge ACLK);
        ARESETN = 1'b1;
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        axi_read(5'h00, 0, rd); check("rst_gie", rd, 32'd0);
        axi_read(5'h04, 0, rd); check("rst_ier", rd, 32'd0);
        axi_read(5'h08, 0, rd); check("rst_isr", rd, 32'd0);
        axi_read(5'h10, 0, rd); check("rst_ipr", rd, 32'd0);

        // Enable, with a stalled write response.
        axi_write(5'h00, 32'h1, 4'hF, 5, 1'b0);
        axi_write(5'h04, 32'h1, 4'hF, 5, 1'b0);
        axi_read(5'h00, 2, rd); check("gie_rb", rd, 32'h1);
        axi_read(5'h04, 1, rd); check("ier_rb", rd, 32'h1);

        // Source 0 rises; irq follows pending by one edge.
        intr_src[0] = 1'b1;
        step(); check("irq_pre", 32'(irq), 32'd0);
        step(); check("irq_post", 32'(irq), 32'd1);
        axi_read(5'h10, 0, rd); check("ipr_set", rd, 32'h1);

        // Ack while the source stays high: no re-trigger.
        axi_write(5'h0C, 32'h1, 4'hF, 0, 1'b0);
        check("irq_acked", 32'(irq), 32'd0);
        axi_read(5'h10, 0, rd); check("ipr_acked", rd, 32'h0);
        axi_read(5'h0C, 0, rd); check("iar_read", rd, 32'h0);
        axi_read(5'h08, 0, rd); check("isr_no_retrig", rd, 32'h0);

        // New edge in the same cycle as the ack commit: set wins.
        intr_src = '0;
        step(); step();
        intr_src[0] = 1'b1;
        step();
        intr_src[0] = 1'b0;
        step(); check("irq_before_race", 32'(irq), 32'd1);
        axi_write(5'h0C, 32'h1, 4'hF, 0, 1'b1);
        check("irq_race", 32'(irq), 32'd1);
        axi_read(5'h08, 0, rd); check("isr_race", rd, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF, 0, 1'b0);
        axi_read(5'h08, 0, rd); check("isr_cleared", rd, 32'h0);

        // Pending latches with GIE off; irq appears once GIE is set.
        axi_write(5'h00, 32'h0, 4'hF, 0, 1'b0);
        intr_src = '0;
        step(); step();
        intr_src[0] = 1'b1;
        step(); step();
        axi_read(5'h08, 0, rd); check("isr_gie_off", rd, 32'h1);
        check("irq_gie_off", 32'(irq), 32'd0);
        axi_write(5'h00, 32'h1, 4'hF, 0, 1'b0);
        check("irq_gie_on", 32'(irq), 32'd1);

        // AW without W, then W without AW: no READY.
        S_AXI_AWADDR  = 5'h04;
        S_AXI_AWVALID = 1'b1;
        repeat (10) begin
            step();
            check("aw_only_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("aw_only_wready", 32'(S_AXI_WREADY), 32'd0);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b1;
        repeat (5) begin
            step();
            check("w_only_wready", 32'(S_AXI_WREADY), 32'd0);
        end
        S_AXI_WVALID = 1'b0;
        step();

        // Unimplemented bits, partial strobes and reserved offsets.
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        axi_read(5'h04, 0, rd); check("ier_width", rd, 32'h0000_000F);
        axi_write(5'h04, 32'h0, 4'h0, 0, 1'b0);
        axi_read(5'h04, 0, rd); check("ier_nostrb", rd, 32'h0000_000F);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        axi_read(5'h14, 0, rd); check("reserved", rd, 32'h0);

        // Random traffic with sources toggling every cycle.
        rand_src = 1'b1;
        for (int it = 0; it < 150; it++) begin
            a = 5'($urandom_range(0, 7) << 2);
            case ($urandom_range(0, 2))
                0: axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), 1'b0);
                1: axi_read(a, int'($urandom_range(0, 2)), rd);
                default: repeat ($urandom_range(1, 3)) step();
            endcase
        end
        rand_src = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
